bg_scroller: RTL and testbench
==============================

# bg_scroller

Parallax scrolling background address generator for the Flappy Bird video path. It sits between the VGA sprite logic and the background ROM. Per pixel, it decides whether the background is visible (no ball, no pipe) and produces a ROM address. That address includes a per-band horizontal scroll offset, advanced once per frame. Output is registered with fixed latency so it lines up with the synchronous background ROM.

## Interface
- IMG_W, 320: background image width in pixels; also the screen window width.
- IMG_H, 480: background image height in rows.
- X_OFF, 160: screen column where the background window starts.
- NUM_LAYERS, 4: number of horizontal parallax bands; IMG_H must be divisible by NUM_LAYERS.
- BASE_SPEED, 1: scroll step of band 0 in pixels/frame. Band k steps BASE_SPEED<<k. Every band step must be < IMG_W.
- ADDR_W, 19: width of bg_addr; must hold IMG_W*IMG_H-1.

- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-low reset.
- frame_clk  in  1  frame pulse (~60 Hz), level signal in Clk domain.
- scroll_en  in  1  1 = offsets advance on frame ticks (game running).
- DrawX, DrawY  in  10 each  current pixel coordinates.
- is_ball, is_pipe  in  1 each  foreground hits for this pixel.
- is_bg  out  1  background visible at the pixel presented 2 cycles earlier.
- bg_addr  out  ADDR_W  ROM address for that pixel.
- layer_idx  out  $clog2(NUM_LAYERS)  band of that pixel (debug/palette select).

## Operation
- **Frame tick**
  - frame_clk is registered once, giving frame_q.
  - tick = frame_clk & ~frame_q (rising edge).
  - A level held high for many cycles yields exactly one tick.
- **Offsets**
  - One register off[k] per band, range 0..IMG_W-1.
  - On tick with scroll_en=1: s = off[k] + (BASE_SPEED<<k). off[k] <= (s >= IMG_W) ? s - IMG_W : s.
  - Otherwise off[k] holds.
  - scroll_en=0 freezes all bands.
- **Stage 1** (registers DrawX, DrawY, is_ball, is_pipe and the derived values):
  - inwin = (DrawX >= X_OFF) & (DrawX < X_OFF+IMG_W) & (DrawY < IMG_H).
  - band = DrawY / (IMG_H/NUM_LAYERS), saturated to NUM_LAYERS-1.
  - col0 = DrawX - X_OFF, truncated to the column width.
- **Stage 2** (output registers):
  - c = col0 + off[band], wrapped by one conditional subtract of IMG_W.
  - bg_addr = DrawY*IMG_W + c when inwin, else 0.
  - is_bg = inwin & ~is_ball & ~is_pipe.
  - layer_idx = band when inwin, else 0.
- **Address vs. visibility**
  - bg_addr is computed regardless of is_ball/is_pipe, so the ROM read is always valid.
  - Only is_bg is masked by the foreground.
- **Arithmetic**
  - All sums are unsigned, with at least one bit of headroom beyond IMG_W before the wrap compare.
  - The multiply is by a constant; no DSP handshake.

## Timing
- **Reset** (Reset=0 sampled at a Clk edge): off[*]=0, frame_q=0, stage-1 registers cleared, is_bg=0, bg_addr=0, layer_idx=0.
- **Latency:** DrawX/DrawY/is_ball/is_pipe at edge n appear on is_bg/bg_addr/layer_idx after edge n+2. The pipeline is continuous, one pixel per cycle, with no stalls.
- **Offset use:**
  - An offset update from a tick detected at edge t is used for stage-2 results from edge t+1 onward.
  - Ticks occur in vertical blanking, so there is no mid-frame tearing. The block does not enforce this.
- **Simultaneous events:**
  - Tick with scroll_en=0: no change.
  - Tick on the same edge as Reset=0: reset wins; offsets read 0.
- **Reset mid-operation:** the pipeline is flushed to reset values on the next edge. Normal output resumes 2 cycles after Reset returns high.
- **Boundaries:**
  - DrawX=X_OFF is column 0.
  - DrawX=X_OFF+IMG_W-1 is the last column.
  - DrawX=X_OFF+IMG_W is out of window.
  - DrawY=IMG_H-1 is the last valid row.

## Test plan
- **Reset:** Reset=0 for 2 cycles, then DrawX=160, DrawY=0, no ball/pipe -> 2 cycles later is_bg=1, bg_addr=0, layer_idx=0.
- **Foreground priority:** DrawX=170, DrawY=10, is_ball=1 (then is_pipe=1) -> is_bg=0, bg_addr=3210 both times.
- **Parallax scroll:** scroll_en=1, 3 frame_clk pulses, each held high 100 cycles.
  - DrawX=160, DrawY=130 -> layer_idx=1, bg_addr=41606 (offset 6).
  - DrawY=10 -> bg_addr=3203 (offset 3).
- **Wrap-around:** 41 ticks -> band 3 offset 8. DrawX=475, DrawY=400 -> column 315+8 wraps to 3, bg_addr=128003, layer_idx=3.
- **Window edges:**
  - DrawX=159 -> is_bg=0, bg_addr=0.
  - DrawX=480 -> is_bg=0.
  - DrawY=480 -> is_bg=0.
  - DrawX=479, DrawY=479, offsets 0 -> bg_addr=153599.
- **Freeze and reset mid-run:**
  - scroll_en=0, 5 ticks -> offsets unchanged.
  - Reset=0 on the same edge as a tick -> all offsets 0; the next pixel at DrawX=160, DrawY=0 gives bg_addr=0 two cycles after Reset releases.

Source files
------------

// File: rtl/bg_scroller.sv
// bg_scroller: parallax background address generator.
// Two-stage pixel pipeline (window/band decode, then scrolled ROM address)
// plus one wrapping horizontal offset per band, advanced on frame ticks.
module bg_scroller #(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned X_OFF      = 160,
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned BASE_SPEED = 1,
  parameter int unsigned ADDR_W     = 19,
  localparam int unsigned LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               scroll_en,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               is_ball,
  input  logic               is_pipe,
  output logic               is_bg,
  output logic [ADDR_W-1:0]  bg_addr,
  output logic [LAYER_W-1:0] layer_idx
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned SUM_W = COL_W + 1;

  localparam logic [11:0]      L_XLO    = 12'(X_OFF);
  localparam logic [11:0]      L_XHI    = 12'(X_OFF + IMG_W);
  localparam logic [11:0]      L_YHI    = 12'(IMG_H);
  localparam logic [9:0]       L_BAND_H = 10'(IMG_H / NUM_LAYERS);
  localparam logic [9:0]       L_BMAX   = 10'(NUM_LAYERS - 1);
  localparam logic [SUM_W-1:0] L_WRAP   = SUM_W'(IMG_W);

  // Frame tick detection
  logic r_frame_q;
  logic w_tick;

  // Per-band offsets
  logic [COL_W-1:0] r_off     [NUM_LAYERS];
  logic [SUM_W-1:0] w_sum     [NUM_LAYERS];
  logic [COL_W-1:0] w_off_nxt [NUM_LAYERS];

  // Stage 1
  logic [11:0]        w_x_ext;
  logic [11:0]        w_y_ext;
  logic               w_inwin;
  logic [9:0]         w_q;
  logic [LAYER_W-1:0] w_band;
  logic [COL_W-1:0]   w_col0;

  logic               r_s1_inwin;
  logic [LAYER_W-1:0] r_s1_band;
  logic [COL_W-1:0]   r_s1_col0;
  logic [9:0]         r_s1_y;
  logic               r_s1_ball;
  logic               r_s1_pipe;

  // Stage 2
  logic [COL_W-1:0]  w_off_sel;
  logic [SUM_W-1:0]  w_c_sum;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_addr;

  assign w_tick = frame_clk & ~r_frame_q;

  // Next value of every band offset: add its step, wrap once at IMG_W
  always_comb begin
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      w_sum[k]     = {1'b0, r_off[k]} + SUM_W'(BASE_SPEED << k);
      w_off_nxt[k] = (w_sum[k] >= L_WRAP) ? COL_W'(w_sum[k] - L_WRAP)
                                          : w_sum[k][COL_W-1:0];
    end
  end

  // Frame-pulse history and offset registers; reset overrides a coincident tick
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_frame_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_LAYERS; k++) r_off[k] <= '0;
    end else begin
      r_frame_q <= frame_clk;
      if (w_tick && scroll_en) begin
        for (int unsigned k = 0; k < NUM_LAYERS; k++) r_off[k] <= w_off_nxt[k];
      end
    end
  end

  // Window test, band select and window-relative column for the incoming pixel
  always_comb begin
    w_x_ext = {2'b00, DrawX};
    w_y_ext = {2'b00, DrawY};
    w_inwin = (w_x_ext >= L_XLO) && (w_x_ext < L_XHI) && (w_y_ext < L_YHI);
    w_q     = DrawY / L_BAND_H;
    w_band  = (w_q >= L_BMAX) ? LAYER_W'(NUM_LAYERS - 1) : w_q[LAYER_W-1:0];
    w_col0  = COL_W'(w_x_ext - L_XLO);
  end

  // Stage-1 pipeline registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_s1_inwin <= 1'b0;
      r_s1_band  <= '0;
      r_s1_col0  <= '0;
      r_s1_y     <= '0;
      r_s1_ball  <= 1'b0;
      r_s1_pipe  <= 1'b0;
    end else begin
      r_s1_inwin <= w_inwin;
      r_s1_band  <= w_band;
      r_s1_col0  <= w_col0;
      r_s1_y     <= DrawY;
      r_s1_ball  <= is_ball;
      r_s1_pipe  <= is_pipe;
    end
  end

  // Scrolled column (single conditional wrap) and row-major ROM address
  always_comb begin
    w_off_sel = r_off[r_s1_band];
    w_c_sum   = {1'b0, r_s1_col0} + {1'b0, w_off_sel};
    w_col     = (w_c_sum >= L_WRAP) ? COL_W'(w_c_sum - L_WRAP)
                                    : w_c_sum[COL_W-1:0];
    w_addr    = ADDR_W'(r_s1_y) * ADDR_W'(IMG_W) + ADDR_W'(w_col);
  end

  // Stage-2 output registers; address ignores foreground so the ROM read stays valid
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      is_bg     <= 1'b0;
      bg_addr   <= '0;
      layer_idx <= '0;
    end else begin
      is_bg     <= r_s1_inwin & ~r_s1_ball & ~r_s1_pipe;
      bg_addr   <= r_s1_inwin ? w_addr : '0;
      layer_idx <= r_s1_inwin ? r_s1_band : '0;
    end
  end

endmodule

// File: tb/tb_bg_scroller.sv
// Directed self-checking bench for bg_scroller with hand-computed addresses.
module tb_bg_scroller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        scroll_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        is_ball = 1'b0;
  logic        is_pipe = 1'b0;
  logic        is_bg;
  logic [18:0] bg_addr;
  logic [1:0]  layer_idx;

  int checks = 0;
  int errors = 0;

  bg_scroller #(
    .IMG_W(320), .IMG_H(480), .X_OFF(160),
    .NUM_LAYERS(4), .BASE_SPEED(1), .ADDR_W(19)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .scroll_en(scroll_en),
    .DrawX(DrawX), .DrawY(DrawY), .is_ball(is_ball), .is_pipe(is_pipe),
    .is_bg(is_bg), .bg_addr(bg_addr), .layer_idx(layer_idx)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setpix(input int x, input int y, input logic b, input logic p);
    @(negedge Clk);
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    is_ball = b;
    is_pipe = p;
  endtask

  // Present one pixel and check the outputs two edges later
  task automatic chkpix(input string tag, input int x, input int y, input logic b,
                        input logic p, input logic ebg, input int eaddr, input int elay);
    setpix(x, y, b, p);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk({tag, ".is_bg"}, 32'(is_bg), 32'(ebg));
    chk({tag, ".bg_addr"}, 32'(bg_addr), 32'(eaddr));
    chk({tag, ".layer_idx"}, 32'(layer_idx), 32'(elay));
  endtask

  task automatic tick(input int hi);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (hi) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.is_bg", 32'(is_bg), 0);
    chk("rst.bg_addr", 32'(bg_addr), 0);
    chk("rst.layer_idx", 32'(layer_idx), 0);
    @(negedge Clk);
    Reset = 1'b1;
    chkpix("first", 160, 0, 0, 0, 1, 0, 0);

    // Foreground masks visibility but not the address
    chkpix("ball", 170, 10, 1, 0, 0, 3210, 0);
    chkpix("pipe", 170, 10, 0, 1, 0, 3210, 0);

    // Window edges and band boundaries, offsets 0
    chkpix("left_out", 159, 0, 0, 0, 0, 0, 0);
    chkpix("right_out", 480, 0, 0, 0, 0, 0, 0);
    chkpix("bottom_out", 200, 480, 0, 0, 0, 0, 0);
    chkpix("corner", 479, 479, 0, 0, 1, 153599, 3);
    chkpix("lastcol", 479, 0, 0, 0, 1, 319, 0);
    chkpix("band0_end", 160, 119, 0, 0, 1, 38080, 0);
    chkpix("band1_start", 160, 120, 0, 0, 1, 38400, 1);

    // Back-to-back pixels, one per cycle
    setpix(161, 1, 0, 0);
    setpix(162, 240, 0, 0);
    @(posedge Clk); #1;
    chk("stream_a.bg_addr", 32'(bg_addr), 321);
    setpix(300, 0, 1, 0);
    @(posedge Clk); #1;
    chk("stream_b.bg_addr", 32'(bg_addr), 76802);
    chk("stream_b.layer_idx", 32'(layer_idx), 2);
    @(posedge Clk); #1;
    chk("stream_c.is_bg", 32'(is_bg), 0);
    chk("stream_c.bg_addr", 32'(bg_addr), 140);

    // Parallax: three long frame pulses -> offsets 3, 6, 12, 24
    scroll_en = 1'b1;
    repeat (3) tick(100);
    chkpix("par_b1", 160, 130, 0, 0, 1, 41606, 1);
    chkpix("par_b0", 160, 10, 0, 0, 1, 3203, 0);
    chkpix("par_b2", 160, 250, 0, 0, 1, 80012, 2);
    chkpix("par_b3", 160, 400, 0, 0, 1, 128024, 3);

    // Wrap-around: from reset, 41 ticks -> offsets 41, 82, 164, 8
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    repeat (41) tick(2);
    chkpix("wrap_b3", 475, 400, 0, 0, 1, 128003, 3);
    chkpix("wrap_b0", 160, 0, 0, 0, 1, 41, 0);
    chkpix("wrap_b0_edge", 479, 0, 0, 0, 1, 40, 0);
    chkpix("wrap_b2", 160, 240, 0, 0, 1, 76964, 2);

    // Freeze: ticks with scroll_en=0 change nothing
    scroll_en = 1'b0;
    repeat (5) tick(2);
    chkpix("frz_b3", 475, 400, 0, 0, 1, 128003, 3);
    chkpix("frz_b0", 160, 0, 0, 0, 1, 41, 0);

    // Offset update visible on the edge after the tick edge
    scroll_en = 1'b1;
    setpix(160, 0, 0, 0);
    @(posedge Clk);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    chk("tick_edge.bg_addr", 32'(bg_addr), 41);
    @(posedge Clk); #1;
    chk("tick_next.bg_addr", 32'(bg_addr), 42);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);

    // Reset coincident with a tick: reset wins, pipeline flushed
    Reset     = 1'b0;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    chk("rst_tick.is_bg", 32'(is_bg), 0);
    chk("rst_tick.bg_addr", 32'(bg_addr), 0);
    @(negedge Clk);
    Reset     = 1'b1;
    frame_clk = 1'b0;
    chkpix("post_rst_b0", 160, 0, 0, 0, 1, 0, 0);
    chkpix("post_rst_b3", 160, 400, 0, 0, 1, 128000, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
